// File: rtl/apu_pkg.sv
// apu_pkg: shared definitions for the APU output mixer.
//   mix_state_e   - mixer sequencer states
//   NUM_CH        - number of sound channels mixed
//   AMP_W         - channel DAC amplitude width
//   VOL_W         - NR50 master volume field width
//   ACC_W         - per-side accumulator width (max 4 * 15 = 60)
//   MIX_W         - scaled mix width (max 60 * 8 = 480)
//   NR50_*/NR51_* - register field bit positions
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } mix_state_e;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned AMP_W  = 4;
  localparam int unsigned VOL_W  = 3;
  localparam int unsigned ACC_W  = 6;
  localparam int unsigned MIX_W  = 9;

  // NR50: bits 6:4 left volume, bits 2:0 right volume (bits 7/3 are Vin, unused)
  localparam int unsigned NR50_LVOL_LSB = 4;
  localparam int unsigned NR50_RVOL_LSB = 0;

  // NR51: bits 7:4 route channels to left, bits 3:0 route channels to right
  localparam int unsigned NR51_LEFT_LSB  = 4;
  localparam int unsigned NR51_RIGHT_LSB = 0;

endpackage

// File: rtl/apu_mixer_if.sv
// apu_mixer_if: signal bundle between the APU register/channel logic and the
// output mixer.
//   sample_tick           - one-cycle request for a new mixed sample
//   ch1..ch4              - channel DAC amplitudes, 0..15
//   nr50, nr51            - master volume and channel routing registers
//   apu_enable            - NR52 bit 7 master enable
//   left_out, right_out   - WIDTH-bit unsigned samples to the pwm DACs
//   valid                 - one-cycle pulse on new left_out/right_out
//   overrun               - sticky dropped-tick flag
// master: the side producing ticks and register values; slave: the mixer.
interface apu_mixer_if
  import apu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic             sample_tick;
  logic [AMP_W-1:0] ch1;
  logic [AMP_W-1:0] ch2;
  logic [AMP_W-1:0] ch3;
  logic [AMP_W-1:0] ch4;
  logic [7:0]       nr50;
  logic [7:0]       nr51;
  logic             apu_enable;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic             valid;
  logic             overrun;

  modport master (
    output sample_tick, ch1, ch2, ch3, ch4, nr50, nr51, apu_enable,
    input  left_out, right_out, valid, overrun
  );

  modport slave (
    input  sample_tick, ch1, ch2, ch3, ch4, nr50, nr51, apu_enable,
    output left_out, right_out, valid, overrun
  );

endinterface

// File: rtl/apu_mix_side.sv
// apu_mix_side: one stereo side of the mixer (accumulator plus volume scaler).
//   clk, reset - clock and synchronous active-high reset
//   clr        - clears the accumulator at the start of a sample
//   add_en     - accumulate phase active this cycle
//   route      - current channel is routed to this side
//   amp        - current channel amplitude
//   vol        - 3-bit master volume for this side
//   mix        - acc * (vol + 1), 9 bits, combinational from the accumulator
module apu_mix_side
  import apu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             add_en,
  input  logic             route,
  input  logic [AMP_W-1:0] amp,
  input  logic [VOL_W-1:0] vol,
  output logic [MIX_W-1:0] mix
);

  logic [ACC_W-1:0] acc_q;
  logic [VOL_W:0]   vol_p1;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_q <= '0;
    end else if (add_en && route) begin
      acc_q <= acc_q + ACC_W'(amp);
    end
  end

  always_comb begin
    vol_p1 = {1'b0, vol} + (VOL_W+1)'(1);
    mix    = MIX_W'(acc_q) * MIX_W'(vol_p1);
  end

endmodule

// File: rtl/apu_mixer.sv
// apu_mixer: combines the four APU channel DAC outputs into left/right
// WIDTH-bit samples for the pwm DAC stage.
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - apu_mixer_if slave: sample_tick, ch1..ch4, nr50, nr51,
//           apu_enable in; left_out, right_out, valid, overrun out
// A tick accepted in IDLE snapshots all inputs, then four ACC cycles sum the
// routed channels, SCALE applies volume, and valid is high during OUT.
module apu_mixer
  import apu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  apu_mixer_if.slave  bus
);

  mix_state_e        state;
  logic [1:0]        idx;

  logic [AMP_W-1:0]  ch_s [NUM_CH];
  logic [VOL_W-1:0]  lvol_s;
  logic [VOL_W-1:0]  rvol_s;
  logic [NUM_CH-1:0] lroute_s;
  logic [NUM_CH-1:0] rroute_s;
  logic              en_s;

  logic [WIDTH-1:0]  left_q;
  logic [WIDTH-1:0]  right_q;
  logic              valid_q;
  logic              overrun_q;

  logic              accept;
  logic              acc_phase;
  logic [AMP_W-1:0]  cur_amp;
  logic [MIX_W-1:0]  left_mix;
  logic [MIX_W-1:0]  right_mix;

  always_comb begin
    accept    = bus.sample_tick && (state == IDLE);
    acc_phase = (state == ACC);
    cur_amp   = ch_s[idx];
  end

  apu_mix_side u_left (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .add_en (acc_phase),
    .route  (lroute_s[idx]),
    .amp    (cur_amp),
    .vol    (lvol_s),
    .mix    (left_mix)
  );

  apu_mix_side u_right (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .add_en (acc_phase),
    .route  (rroute_s[idx]),
    .amp    (cur_amp),
    .vol    (rvol_s),
    .mix    (right_mix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_s[i] <= '0;
      end
      lvol_s    <= '0;
      rvol_s    <= '0;
      lroute_s  <= '0;
      rroute_s  <= '0;
      en_s      <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // Ticks outside IDLE are dropped, never queued.
      if (bus.sample_tick && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.sample_tick) begin
            ch_s[0]  <= bus.ch1;
            ch_s[1]  <= bus.ch2;
            ch_s[2]  <= bus.ch3;
            ch_s[3]  <= bus.ch4;
            lvol_s   <= bus.nr50[NR50_LVOL_LSB +: VOL_W];
            rvol_s   <= bus.nr50[NR50_RVOL_LSB +: VOL_W];
            lroute_s <= bus.nr51[NR51_LEFT_LSB +: NUM_CH];
            rroute_s <= bus.nr51[NR51_RIGHT_LSB +: NUM_CH];
            en_s     <= bus.apu_enable;
            idx      <= '0;
            state    <= ACC;
          end
        end
        ACC: begin
          idx <= idx + 2'd1;
          if (idx == 2'(NUM_CH - 1)) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          // Left-justify the 9-bit mix into the WIDTH-bit DAC word.
          left_q  <= en_s ? (WIDTH'(left_mix)  << (WIDTH - MIX_W)) : '0;
          right_q <= en_s ? (WIDTH'(right_mix) << (WIDTH - MIX_W)) : '0;
          valid_q <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.left_out  = left_q;
  assign bus.right_out = right_q;
  assign bus.valid     = valid_q;
  assign bus.overrun   = overrun_q;

endmodule
